// File: rtl/pacman_mover.sv
// Pac-Man player mover: turns debounced buttons into maze-constrained moves on the slow
// clock and sequences the death, respawn and game-over flow driven by the ghost's p_dead.
module pacman_mover #(
  parameter int STEP        = 2,
  parameter int SPAWN_X     = 330,
  parameter int SPAWN_Y     = 380,
  parameter int LIVES       = 3,
  parameter int DEATH_TICKS = 16,
  parameter int SPRITE      = 20
) (
  input  logic       clk_10,
  input  logic       rst,
  input  logic       clk_s,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       p_dead,
  output logic [9:0] x_reg,
  output logic [9:0] y_reg,
  output logic [1:0] dir,
  output logic [1:0] lives,
  output logic       dying,
  output logic       game_over,
  output logic       ghost_rst
);

  localparam int CW = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS) : 1;

  typedef enum logic [2:0] {ALIVE, DYING, RESPAWN, WAIT_CLR, GAME_OVER} state_t;

  state_t        state;
  logic [CW-1:0] death_cnt;
  logic [1:0]    s_sync;
  logic          s_prev;
  logic          tick;

  logic       req_valid, req_ok, dir_ok, do_move;
  logic [1:0] req_dir, step_dir;
  logic [9:0] nx_next, ny_next;

  // Strict overlap of the sprite box at (nx, ny) with one wall rectangle.
  function automatic logic hits(input logic [10:0] nx, input logic [10:0] ny,
                                input int l, input int r, input int t, input int b);
    return (11'(l) < nx + 11'(SPRITE)) && (nx < 11'(r)) &&
           (11'(t) < ny + 11'(SPRITE)) && (ny < 11'(b));
  endfunction

  function automatic logic move_blocked(input logic [1:0] d, input logic [9:0] x,
                                        input logic [9:0] y);
    logic [10:0] nx;
    logic [10:0] ny;
    logic        under;
    nx    = {1'b0, x};
    ny    = {1'b0, y};
    under = 1'b0;
    case (d)
      2'b00: begin
        under = (y < 10'(STEP));
        ny    = ny - 11'(STEP);
      end
      2'b01: ny = ny + 11'(STEP);
      2'b10: begin
        under = (x < 10'(STEP));
        nx    = nx - 11'(STEP);
      end
      default: nx = nx + 11'(STEP);
    endcase
    return under || (nx < 11'd70) || (nx + 11'(SPRITE) > 11'd580) ||
           (ny < 11'd70) || (ny + 11'(SPRITE) > 11'd410) ||
           hits(nx, ny, 260, 400, 240, 260) || hits(nx, ny, 110, 210, 110, 130) ||
           hits(nx, ny, 440, 540, 110, 130) || hits(nx, ny, 110, 210, 350, 370) ||
           hits(nx, ny, 440, 540, 350, 370) || hits(nx, ny, 180, 200, 160, 280) ||
           hits(nx, ny, 500, 520, 160, 280);
  endfunction

  // clk_s crosses domains through two flops; the rise becomes a one-cycle tick.
  always_ff @(posedge clk_10 or posedge rst) begin
    if (rst) begin
      s_sync <= 2'b00;
      s_prev <= 1'b0;
    end else begin
      s_sync <= {s_sync[0], clk_s};
      s_prev <= s_sync[1];
    end
  end

  assign tick = s_sync[1] & ~s_prev;

  always_comb begin
    req_valid = btn_u | btn_d | btn_l | btn_r;
    req_dir   = btn_u ? 2'b00 : btn_d ? 2'b01 : btn_l ? 2'b10 : 2'b11;
    req_ok    = req_valid && !move_blocked(req_dir, x_reg, y_reg);
    dir_ok    = !move_blocked(dir, x_reg, y_reg);
    do_move   = req_ok || dir_ok;
    step_dir  = req_ok ? req_dir : dir;
    nx_next   = x_reg;
    ny_next   = y_reg;
    case (step_dir)
      2'b00:   ny_next = y_reg - 10'(STEP);
      2'b01:   ny_next = y_reg + 10'(STEP);
      2'b10:   nx_next = x_reg - 10'(STEP);
      default: nx_next = x_reg + 10'(STEP);
    endcase
  end

  // Respawn values are loaded on leaving DYING so they are visible during the ghost_rst pulse.
  always_ff @(posedge clk_10 or posedge rst) begin
    if (rst) begin
      state     <= ALIVE;
      death_cnt <= '0;
      x_reg     <= 10'(SPAWN_X);
      y_reg     <= 10'(SPAWN_Y);
      dir       <= 2'b10;
      lives     <= 2'(LIVES);
      dying     <= 1'b0;
      game_over <= 1'b0;
      ghost_rst <= 1'b0;
    end else begin
      case (state)
        ALIVE: begin
          if (p_dead) begin
            lives     <= lives - 2'd1;
            death_cnt <= '0;
            dying     <= 1'b1;
            state     <= DYING;
          end else if (tick && do_move) begin
            x_reg <= nx_next;
            y_reg <= ny_next;
            dir   <= step_dir;
          end
        end
        DYING: begin
          if (tick) begin
            if (death_cnt == CW'(DEATH_TICKS - 1)) begin
              dying <= 1'b0;
              if (lives == 2'd0) begin
                game_over <= 1'b1;
                state     <= GAME_OVER;
              end else begin
                x_reg     <= 10'(SPAWN_X);
                y_reg     <= 10'(SPAWN_Y);
                dir       <= 2'b10;
                ghost_rst <= 1'b1;
                state     <= RESPAWN;
              end
            end else begin
              death_cnt <= death_cnt + 1'b1;
            end
          end
        end
        RESPAWN: begin
          ghost_rst <= 1'b0;
          state     <= WAIT_CLR;
        end
        WAIT_CLR: begin
          if (!p_dead) state <= ALIVE;
        end
        GAME_OVER: begin
          game_over <= 1'b1;
        end
        default: state <= ALIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_pacman_mover.sv
// Scoreboard bench for pacman_mover: expected outputs are queued as each clk_s rise is
// driven and compared three clk_10 edges later, when the move must have landed.
module tb_pacman_mover;

  logic       clk_10 = 1'b0;
  logic       rst    = 1'b0;
  logic       clk_s  = 1'b0;
  logic       btn_u  = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
  logic       p_dead = 1'b0;
  logic [9:0] x_reg, y_reg;
  logic [1:0] dir, lives;
  logic       dying, game_over, ghost_rst;

  typedef struct {
    int x; int y; int d; int lv; int dy; int go; int gr;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   gr_pulses = 0;

  pacman_mover dut (
    .clk_10(clk_10), .rst(rst), .clk_s(clk_s),
    .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
    .p_dead(p_dead), .x_reg(x_reg), .y_reg(y_reg), .dir(dir), .lives(lives),
    .dying(dying), .game_over(game_over), .ghost_rst(ghost_rst)
  );

  always #5 clk_10 = ~clk_10;

  always @(posedge clk_10) if (ghost_rst) gr_pulses++;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic compare_all(input string tag, input exp_t e);
    check_output({tag, ".x"},     int'(x_reg),     e.x);
    check_output({tag, ".y"},     int'(y_reg),     e.y);
    check_output({tag, ".dir"},   int'(dir),       e.d);
    check_output({tag, ".lives"}, int'(lives),     e.lv);
    check_output({tag, ".dying"}, int'(dying),     e.dy);
    check_output({tag, ".go"},    int'(game_over), e.go);
    check_output({tag, ".grst"},  int'(ghost_rst), e.gr);
  endtask

  task automatic push_exp(input int x, input int y, input int d, input int lv,
                          input int dy, input int go, input int gr);
    exp_t e;
    e = '{x: x, y: y, d: d, lv: lv, dy: dy, go: go, gr: gr};
    exp_q.push_back(e);
  endtask

  // One clk_s rise; optionally checks nothing changed before the 3rd edge and raises
  // p_dead so it coincides with the tick cycle.
  task automatic apply_stimulus(input string tag, input bit dead_on_tick, input bit chk_pre);
    exp_t e;
    repeat (3) @(posedge clk_10);
    @(negedge clk_10);
    clk_s = 1'b1;
    @(posedge clk_10);
    @(posedge clk_10);
    #1;
    if (chk_pre) begin
      check_output({tag, ".pre_x"}, int'(x_reg), cur.x);
      check_output({tag, ".pre_y"}, int'(y_reg), cur.y);
    end
    if (dead_on_tick) p_dead = 1'b1;
    @(posedge clk_10);
    #1;
    if (exp_q.size() == 0) begin
      check_output({tag, ".queue_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      compare_all(tag, e);
      cur = e;
    end
    clk_s = 1'b0;
  endtask

  task automatic do_reset();
    exp_t e;
    rst = 1'b1;
    repeat (2) @(posedge clk_10);
    #1;
    push_exp(330, 380, 2, 3, 0, 0, 0);
    e = exp_q.pop_front();
    compare_all("reset", e);
    cur = e;
    rst = 1'b0;
    @(posedge clk_10);
  endtask

  // Death tick plus the first 15 DYING ticks; the caller queues the 16th outcome.
  task automatic die_at(input int x, input int y, input int d, input int lv_after);
    push_exp(x, y, d, lv_after, 1, 0, 0);
    apply_stimulus("death_tick", 1'b1, 1'b1);
    for (int i = 1; i < 16; i++) begin
      push_exp(x, y, d, lv_after, 1, 0, 0);
      apply_stimulus("dying", 1'b0, 1'b0);
    end
  endtask

  initial begin
    int base;
    rst = 1'b1;
    #23;
    do_reset();

    btn_l = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      push_exp(330 - 2 * k, 380, 2, 3, 0, 0, 0);
      apply_stimulus("free_move", 1'b0, 1'b1);
    end
    btn_l = 1'b0;

    do_reset();
    btn_d = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      push_exp(330, (k <= 5) ? 380 + 2 * k : 390, 1, 3, 0, 0, 0);
      apply_stimulus("wall_stop", 1'b0, 1'b1);
    end
    btn_d = 1'b0;

    do_reset();
    btn_u = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      push_exp(330, 380 - 2 * k, 0, 3, 0, 0, 0);
      apply_stimulus("climb", 1'b0, 1'b0);
    end
    btn_u = 1'b0;
    btn_l = 1'b1;
    push_exp(328, 260, 2, 3, 0, 0, 0);
    apply_stimulus("turn_left", 1'b0, 1'b0);
    btn_l = 1'b0;
    btn_u = 1'b1;
    for (int k = 1; k <= 44; k++) begin
      push_exp(328 - 2 * k, 260, 2, 3, 0, 0, 0);
      apply_stimulus("corner_slide", 1'b0, 1'b0);
    end
    push_exp(240, 258, 0, 3, 0, 0, 0);
    apply_stimulus("corner_up", 1'b0, 1'b1);
    btn_u = 1'b0;

    do_reset();
    btn_l = 1'b1;
    push_exp(328, 380, 2, 3, 0, 0, 0);
    apply_stimulus("pre_death", 1'b0, 1'b1);
    base = gr_pulses;
    die_at(328, 380, 2, 2);
    push_exp(330, 380, 2, 2, 0, 0, 1);
    apply_stimulus("respawn", 1'b0, 1'b1);
    @(posedge clk_10);
    #1;
    check_output("ghost_rst_width", int'(ghost_rst), 0);
    check_output("ghost_rst_count", gr_pulses - base, 1);
    for (int k = 0; k < 3; k++) begin
      push_exp(330, 380, 2, 2, 0, 0, 0);
      apply_stimulus("wait_clr", 1'b0, 1'b1);
    end
    p_dead = 1'b0;
    push_exp(328, 380, 2, 2, 0, 0, 0);
    apply_stimulus("after_clear", 1'b0, 1'b1);
    btn_l = 1'b0;

    die_at(328, 380, 2, 1);
    push_exp(330, 380, 2, 1, 0, 0, 1);
    apply_stimulus("respawn2", 1'b0, 1'b1);
    repeat (2) @(posedge clk_10);
    p_dead = 1'b0;
    repeat (2) @(posedge clk_10);
    base = gr_pulses;
    die_at(330, 380, 2, 0);
    push_exp(330, 380, 2, 0, 0, 1, 0);
    apply_stimulus("game_over", 1'b0, 1'b1);
    p_dead = 1'b0;
    btn_r = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_exp(330, 380, 2, 0, 0, 1, 0);
      apply_stimulus("go_frozen", 1'b0, 1'b1);
    end
    btn_r = 1'b0;
    check_output("go_no_ghost_rst", gr_pulses - base, 0);

    do_reset();
    die_at_partial: begin
      push_exp(330, 380, 2, 2, 1, 0, 0);
      apply_stimulus("death_tick_b", 1'b1, 1'b1);
      for (int i = 1; i <= 7; i++) begin
        push_exp(330, 380, 2, 2, 1, 0, 0);
        apply_stimulus("dying_b", 1'b0, 1'b0);
      end
    end
    @(negedge clk_10);
    rst = 1'b1;
    p_dead = 1'b0;
    #1;
    push_exp(330, 380, 2, 3, 0, 0, 0);
    cur = exp_q.pop_front();
    compare_all("mid_dying_rst", cur);
    repeat (2) @(posedge clk_10);
    rst = 1'b0;
    btn_l = 1'b1;
    push_exp(328, 380, 2, 3, 0, 0, 0);
    apply_stimulus("alive_after_rst", 1'b0, 1'b1);
    btn_l = 1'b0;

    check_output("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
